// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream decryptor: FSM state encoding and
// the set of plaintext characters accepted as valid output.
package rc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_SI,
    READ_SJ,
    WRITE_SI,
    WRITE_SJ,
    READ_F,
    WRITE_OUT,
    DONE
  } rc4_state_e;

  localparam logic [7:0] CHAR_SPACE   = 8'h20;
  localparam logic [7:0] CHAR_LOWER_A = 8'h61;
  localparam logic [7:0] CHAR_LOWER_Z = 8'h7A;

  // A plaintext byte is acceptable if it is a lowercase letter or a space.
  function automatic logic is_printable(input logic [7:0] c);
    return (c == CHAR_SPACE) || ((c >= CHAR_LOWER_A) && (c <= CHAR_LOWER_Z));
  endfunction

endpackage

// File: rtl/trap_edge.sv
// Rising-edge detector for a synchronous level input. The history flop resets
// high so a level already high when reset releases is not seen as an edge.
module trap_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Remember the previously sampled level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_q <= 1'b1;
    else          level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/rc4_prga_decryptor.sv
// RC4 PRGA decryptor. Walks a pre-shuffled S array held in an external
// synchronous RAM, produces one keystream byte per message byte, XORs it with
// the ciphertext ROM and writes the plaintext RAM. The run stops early on the
// first byte that is not a lowercase letter or space.
//
// Memory handshake: every read registers its address on entry to a READ_*
// state; the memory samples it at the end of the first cycle and q is captured
// at the end of the second. Writes are single cycles with wren held for exactly
// that cycle. s_wren and d_wren are never high together.
//
// Internally i holds the already-incremented index for the byte in flight.
module rc4_prga_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_LENGTH     = 8,
  parameter int MESSAGE_LENGTH = 32,
  parameter int MSG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      finished,
  output logic                      success,
  output logic [RAM_LENGTH-1:0]     s_address,
  output logic [RAM_WIDTH-1:0]      s_data,
  output logic                      s_wren,
  input  logic [RAM_WIDTH-1:0]      s_q,
  output logic [MSG_ADDR_WIDTH-1:0] m_address,
  input  logic [7:0]                m_q,
  output logic [MSG_ADDR_WIDTH-1:0] d_address,
  output logic [7:0]                d_data,
  output logic                      d_wren,
  output rc4_state_e                fsm_state
);

  localparam logic [MSG_ADDR_WIDTH-1:0] LAST_K = MSG_ADDR_WIDTH'(MESSAGE_LENGTH - 1);
  localparam logic [RAM_LENGTH-1:0]     ONE_I  = RAM_LENGTH'(1);

  rc4_state_e                state, state_n;
  logic                      phase, phase_n;
  logic [RAM_LENGTH-1:0]     i, i_n, j, j_n;
  logic [MSG_ADDR_WIDTH-1:0] k, k_n;
  logic [RAM_WIDTH-1:0]      si, si_n, sj, sj_n, f, f_n;
  logic [7:0]                m_byte, m_byte_n;
  logic [RAM_LENGTH-1:0]     s_address_n;
  logic [RAM_WIDTH-1:0]      s_data_n;
  logic                      s_wren_n;
  logic [MSG_ADDR_WIDTH-1:0] m_address_n, d_address_n;
  logic [7:0]                d_data_n;
  logic                      d_wren_n;
  logic                      finished_n, success_n;
  logic                      start_rise;
  logic [RAM_LENGTH-1:0]     j_sum, f_index;
  logic [7:0]                plain;

  trap_edge u_start_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (start),
    .rise    (start_rise)
  );

  assign j_sum     = j + RAM_LENGTH'(s_q);
  assign f_index   = RAM_LENGTH'(si) + RAM_LENGTH'(sj);
  assign plain     = 8'(f) ^ m_byte;
  assign fsm_state = state;

  // Register the FSM state together with every datapath register and output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= 1'b0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      sj        <= '0;
      f         <= '0;
      m_byte    <= '0;
      s_address <= '0;
      s_data    <= '0;
      s_wren    <= 1'b0;
      m_address <= '0;
      d_address <= '0;
      d_data    <= '0;
      d_wren    <= 1'b0;
      finished  <= 1'b0;
      success   <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      i         <= i_n;
      j         <= j_n;
      k         <= k_n;
      si        <= si_n;
      sj        <= sj_n;
      f         <= f_n;
      m_byte    <= m_byte_n;
      s_address <= s_address_n;
      s_data    <= s_data_n;
      s_wren    <= s_wren_n;
      m_address <= m_address_n;
      d_address <= d_address_n;
      d_data    <= d_data_n;
      d_wren    <= d_wren_n;
      finished  <= finished_n;
      success   <= success_n;
    end
  end

  // Next-state and next-output logic; write enables default low every cycle.
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    i_n         = i;
    j_n         = j;
    k_n         = k;
    si_n        = si;
    sj_n        = sj;
    f_n         = f;
    m_byte_n    = m_byte;
    s_address_n = s_address;
    s_data_n    = s_data;
    s_wren_n    = 1'b0;
    m_address_n = m_address;
    d_address_n = d_address;
    d_data_n    = d_data;
    d_wren_n    = 1'b0;
    finished_n  = finished;
    success_n   = success;

    case (state)
      IDLE, DONE: begin
        if (start_rise) begin
          state_n     = READ_SI;
          phase_n     = 1'b0;
          i_n         = ONE_I;
          j_n         = '0;
          k_n         = '0;
          finished_n  = 1'b0;
          success_n   = 1'b0;
          s_address_n = ONE_I;
        end
      end

      READ_SI: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n     = 1'b0;
          si_n        = s_q;
          j_n         = j_sum;
          s_address_n = j_sum;
          state_n     = READ_SJ;
        end
      end

      READ_SJ: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n     = 1'b0;
          sj_n        = s_q;
          s_address_n = i;
          s_data_n    = s_q;
          s_wren_n    = 1'b1;
          state_n     = WRITE_SI;
        end
      end

      WRITE_SI: begin
        s_address_n = j;
        s_data_n    = si;
        s_wren_n    = 1'b1;
        state_n     = WRITE_SJ;
      end

      WRITE_SJ: begin
        s_address_n = f_index;
        m_address_n = k;
        state_n     = READ_F;
      end

      READ_F: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n     = 1'b0;
          f_n         = s_q;
          m_byte_n    = m_q;
          d_address_n = k;
          d_data_n    = 8'(s_q) ^ m_q;
          d_wren_n    = 1'b1;
          state_n     = WRITE_OUT;
        end
      end

      WRITE_OUT: begin
        if (!is_printable(plain)) begin
          state_n    = DONE;
          finished_n = 1'b1;
          success_n  = 1'b0;
        end else if (k == LAST_K) begin
          state_n    = DONE;
          finished_n = 1'b1;
          success_n  = 1'b1;
        end else begin
          k_n         = k + MSG_ADDR_WIDTH'(1);
          i_n         = i + ONE_I;
          s_address_n = i + ONE_I;
          state_n     = READ_SI;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/rc4_prga_decryptor.md
RC4_PRGA_DECRYPTOR -- requirements
Module: rc4_prga_decryptor

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, S-array data width.
REQ-002 SHALL have parameter RAM_LENGTH, default 8, S-array address width (256 entries).
REQ-003 SHALL have parameter MESSAGE_LENGTH, default 32, number of ciphertext/plaintext bytes.
REQ-004 SHALL have parameter MSG_ADDR_WIDTH, default 5, ciphertext ROM and plaintext RAM address width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports below.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  level input; rising edge launches a run.
REQ-009 finished  out  1  run complete, held until next start edge.
REQ-010 success  out  1  valid with finished; 1 = every byte in 0x61..0x7A or 0x20.
REQ-011 s_address / s_data / s_wren / s_q  out RAM_LENGTH / out RAM_WIDTH / out 1 / in RAM_WIDTH  shuffled S-array RAM port.
REQ-012 m_address / m_q  out MSG_ADDR_WIDTH / in 8  ciphertext ROM port.
REQ-013 d_address / d_data / d_wren  out MSG_ADDR_WIDTH / out 8 / out 1  plaintext RAM port.

Function
REQ-014 SHALL implement RC4 PRGA: i=0,j=0; per byte k: i=i+1; j=j+s[i]; swap s[i],s[j]; d[k]=s[(s[i]+s[j])] XOR m[k].
REQ-015 SHALL do all i, j, index sums in RAM_LENGTH bits, wrapping mod 256 with no saturation.
REQ-016 SHALL treat RAM/ROM as synchronous: q valid the cycle after a registered address; all outputs registered.
REQ-017 SHALL detect start by rising edge only; a held-high start does not relaunch.
REQ-018 States: IDLE, READ_SI, READ_SJ, WRITE_SI, WRITE_SJ, READ_F, WRITE_OUT, DONE.
REQ-019 READ_SI, READ_SJ, READ_F: 2 cycles each (issue address, capture q); WRITE_SI, WRITE_SJ, WRITE_OUT: 1 cycle each; 9 cycles per byte.
REQ-020 READ_SI: s_address=i+1; capture si; j<=j+si.
REQ-021 READ_SJ: s_address=new j; capture sj.
REQ-022 WRITE_SI: s[i]<=sj, s_wren=1; WRITE_SJ: s[j]<=si, s_wren=1.
REQ-023 READ_F: s_address=si+sj and m_address=k in the same cycle; capture f and m_q.
REQ-024 WRITE_OUT: d_address=k, d_data=f XOR m_q, d_wren=1; s_wren=0.
REQ-025 On a plaintext byte outside 0x61..0x7A and not 0x20: still write it, then go to DONE with success=0 (early abort).
REQ-026 After k=MESSAGE_LENGTH-1 passes: go to DONE with success=1; no further RAM/ROM writes.
REQ-027 i==j (including wrap i=255->0): both swap writes still issued, same value; no corruption.
REQ-028 DONE: finished=1 held; next start rising edge clears finished/success, zeroes i, j, k, and enters READ_SI.
REQ-029 s_wren and d_wren SHALL never be asserted in the same cycle; never asserted in IDLE or DONE.

Reset
REQ-030 reset_n low SHALL immediately force IDLE; i, j, k, si, sj, f = 0; all addresses/data = 0; s_wren, d_wren, finished, success = 0.
REQ-031 Reset mid-run SHALL abandon the run without finishing writes; no write after reset_n falls.
REQ-032 After reset_n rises, a start edge SHALL be required to begin; a start held high through reset does not launch.

Structure
REQ-033 State enum and the printable-range constants (0x20, 0x61, 0x7A) SHALL live in shared package rc4_pkg.
REQ-034 Start edge detection SHALL reuse the existing trap_edge sub-module; no other sub-modules.

Verification
REQ-035 S identity (s[x]=x), m[0]=0x63, m[1]=0x64 -> d[0]=0x61, d[1]=0x61; s[2]=3, s[3]=2 after byte 1.
REQ-036 Identity S, m chosen so all 32 plaintext bytes are 'a' -> finished=1, success=1 at cycle 9*32+small fixed overhead; 32 d writes.
REQ-037 Identity S, m[0]=0x00 -> d[0]=0x02 written, then finished=1, success=0; no second d write.
REQ-038 reset_n pulsed low mid-WRITE_SI -> s_wren=0 same cycle; IDLE; new start edge restarts from byte 0, correct output.
REQ-039 start held high after DONE -> no relaunch; fall then rise -> finished clears next cycle, run repeats.
REQ-040 S with s[1]=0xFF (forces j wrap) -> j=0xFF, swap of s[1], s[255] observed; d[0] matches software model.
